// File: rtl/byte_data_mem.sv
// byte_data_mem: word-organised data memory with byte-enable writes, an
// optional fixed stall per access, and a registered one-cycle response.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          synchronous active-high reset (memory contents kept)
//   mem_req_i      request strobe, taken when ready_o=1
//   write_enable_i 1 = write, 0 = read
//   byte_enable_i  per-byte write mask (ignored for reads)
//   addr_i         byte address, bits [1:0] ignored
//   write_data_i   write data
//   ready_o        block can accept a request this cycle
//   rvalid_o       one-cycle response pulse
//   err_o          out-of-range flag, meaningful only with rvalid_o
//   read_data_o    response data (fa11_1eaf when idle or for writes)
module byte_data_mem #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        write_enable_i,
    input  logic [3:0]  byte_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic        err_o,
    output logic [31:0] read_data_o
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
    localparam logic [31:0] IDLE_VAL = 32'hfa11_1eaf;
    localparam logic [31:0] ERR_VAL  = 32'hdead_beef;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_rvalid;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_exec;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_oor;
    logic [AW-1:0] w_idx;

    // With no stall the access runs straight off the inputs at the
    // acceptance edge; otherwise it runs off the request captured at
    // acceptance, when the down-counter reaches 1.
    generate
        if (WAIT_CYCLES == 0) begin : g_nowait
            assign w_exec  = (r_state == S_IDLE) && mem_req_i;
            assign w_we    = write_enable_i;
            assign w_be    = byte_enable_i;
            assign w_addr  = addr_i;
            assign w_wdata = write_data_i;
        end else begin : g_wait
            logic        r_we;
            logic [3:0]  r_be;
            logic [31:0] r_addr;
            logic [31:0] r_wdata;

            always_ff @(posedge clk_i) begin
                if (r_state == S_IDLE && mem_req_i) begin
                    r_we    <= write_enable_i;
                    r_be    <= byte_enable_i;
                    r_addr  <= addr_i;
                    r_wdata <= write_data_i;
                end
            end

            assign w_exec  = (r_state == S_WAIT) && (r_cnt == 4'd1);
            assign w_we    = r_we;
            assign w_be    = r_be;
            assign w_addr  = r_addr;
            assign w_wdata = r_wdata;
        end
    endgenerate

    // Full 32-bit range check, so aliasing high addresses are rejected.
    assign w_oor = {1'b0, w_addr} >= LIMIT;
    assign w_idx = w_addr[AW+1:2];

    // Storage is never reset; a reset at the execution edge suppresses
    // the write, which also drops an access pending in WAIT.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_exec && w_we && !w_oor) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= IDLE_VAL;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= IDLE_VAL;

            case (r_state)
                S_IDLE: begin
                    if (mem_req_i && WAIT_CYCLES != 0) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 4'(WAIT_CYCLES);
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_exec) begin
                r_rvalid <= 1'b1;
                if (w_oor) begin
                    r_err   <= 1'b1;
                    r_rdata <= ERR_VAL;
                end else if (!w_we) begin
                    // Old contents: a same-edge write lands after this read.
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

    assign ready_o     = (r_state == S_IDLE);
    assign rvalid_o    = r_rvalid;
    assign err_o       = r_err;
    assign read_data_o = r_rdata;
endmodule

// File: tb/tb_byte_data_mem.sv
// Bench for byte_data_mem: two instances (no stall and a 3-cycle stall)
// driven by the same stimulus, each checked every cycle against a
// transaction-level model, plus directed scenarios with literal values.
module tb_byte_data_mem;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  rdy, rv, er;
    logic [31:0] rd0, rd1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    byte_data_mem #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req), .write_enable_i(we),
        .byte_enable_i(be), .addr_i(addr), .write_data_i(wd),
        .ready_o(rdy[0]), .rvalid_o(rv[0]), .err_o(er[0]), .read_data_o(rd0));

    byte_data_mem #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req), .write_enable_i(we),
        .byte_enable_i(be), .addr_i(addr), .write_data_i(wd),
        .ready_o(rdy[1]), .rvalid_o(rv[1]), .err_o(er[1]), .read_data_o(rd1));

    // ---------------- transaction-level model ----------------
    int          wcyc [2] = '{0, 3};
    logic [31:0] mmem  [2][DEPTH];
    bit   [3:0]  mknown[2][DEPTH];
    longint      edge_n = 0;
    longint      free_e [2] = '{0, 0};
    bit          pend   [2] = '{0, 0};
    longint      pend_x [2];
    bit          p_we   [2];
    logic [3:0]  p_be   [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wd   [2];
    bit          e_rdy [2], e_rv [2], e_err [2];
    logic [31:0] e_rd  [2];
    logic [3:0]  e_mask[2];
    bit          started = 0;

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) mknown[d][i] = 4'h0;
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            e_rv[d] = 0; e_err[d] = 0; e_rd[d] = 32'hfa11_1eaf; e_mask[d] = 4'hf;
            if (rst) begin
                pend[d]   = 0;
                free_e[d] = edge_n + 1;
            end else begin
                if (req && edge_n >= free_e[d]) begin
                    pend[d] = 1; pend_x[d] = edge_n + wcyc[d];
                    p_we[d] = we; p_be[d] = be; p_addr[d] = addr; p_wd[d] = wd;
                    free_e[d] = edge_n + wcyc[d] + 1;
                end
                if (pend[d] && pend_x[d] == edge_n) begin
                    int idx;
                    pend[d] = 0;
                    e_rv[d] = 1;
                    idx = int'(p_addr[d] / 4) % DEPTH;
                    if (p_addr[d] >= 32'(4 * DEPTH)) begin
                        e_err[d] = 1; e_rd[d] = 32'hdead_beef;
                    end else if (p_we[d]) begin
                        for (int k = 0; k < 4; k++)
                            if (p_be[d][k]) begin
                                mmem[d][idx][8*k +: 8] = p_wd[d][8*k +: 8];
                                mknown[d][idx][k] = 1'b1;
                            end
                    end else begin
                        e_rd[d]   = mmem[d][idx];
                        e_mask[d] = mknown[d][idx];
                    end
                end
            end
            e_rdy[d] = (edge_n + 1 >= free_e[d]);
        end
        if (rst) started = 1;
        edge_n++;
    end

    // ---------------- per-cycle compare ----------------
    function automatic logic [31:0] bmask(input logic [3:0] m);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = {8{m[k]}};
        return r;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                logic [31:0] got_rd, msk;
                got_rd = (d == 0) ? rd0 : rd1;
                msk    = bmask(e_mask[d]);
                n_vec++;
                if (rdy[d] !== e_rdy[d]) begin
                    n_err++; $display("FAIL ready dut%0d t=%0t got %b exp %b", d, $time, rdy[d], e_rdy[d]);
                end
                n_vec++;
                if (rv[d] !== e_rv[d]) begin
                    n_err++; $display("FAIL rvalid dut%0d t=%0t got %b exp %b", d, $time, rv[d], e_rv[d]);
                end
                n_vec++;
                if (er[d] !== e_err[d]) begin
                    n_err++; $display("FAIL err dut%0d t=%0t got %b exp %b", d, $time, er[d], e_err[d]);
                end
                n_vec++;
                if ((got_rd & msk) !== (e_rd[d] & msk)) begin
                    n_err++; $display("FAIL rdata dut%0d t=%0t got %h exp %h mask %h", d, $time, got_rd, e_rd[d], msk);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit r, input bit q, input bit w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] data);
        rst = r; req = q; we = w; be = b; addr = a; wd = data;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++; $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       return 32'h0000_4000 + $urandom_range(0, 7);
            1:       return 32'hffff_fffc | 32'($urandom_range(0, 3));
            2:       return 32'h0000_3ffc + $urandom_range(0, 3);
            3:       return $urandom;
            default: return 32'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        rst = 1; req = 0; we = 0; be = 0; addr = 0; wd = 0;
        @(posedge clk); #1;
        // reset presented together with a request: request ignored
        step(1, 1, 1, 4'hf, 32'h10, 32'h5555_5555);
        chk("reset_ready0", 32'(rdy[0]), 32'd1);
        chk("reset_ready3", 32'(rdy[1]), 32'd1);
        chk("reset_rdata0", rd0, 32'hfa11_1eaf);
        chk("reset_rvalid3", 32'(rv[1]), 32'd0);

        // back-to-back write then read on the no-stall instance
        step(0, 1, 1, 4'hf, 32'h10, 32'h1234_5678);
        chk("wr_resp_valid", 32'(rv[0]), 32'd1);
        chk("wr_resp_data", rd0, 32'hfa11_1eaf);
        step(0, 1, 0, 4'h0, 32'h10, 32'h0);
        chk("rd_resp_valid", 32'(rv[0]), 32'd1);
        chk("rd_resp_data", rd0, 32'h1234_5678);

        // partial byte write over existing data
        step(0, 1, 1, 4'hf, 32'h20, 32'h1122_3344);
        step(0, 1, 1, 4'b0101, 32'h20, 32'haabb_ccdd);
        step(0, 1, 0, 4'h0, 32'h20, 32'h0);
        chk("be0101_merge", rd0, 32'h11bb_33dd);

        // range boundary
        step(0, 1, 1, 4'hf, 32'h0, 32'h0bad_f00d);
        step(0, 1, 1, 4'hf, 32'h3ffc, 32'h7777_8888);
        step(0, 1, 0, 4'h0, 32'h4000, 32'h0);
        chk("oor_rd_data", rd0, 32'hdead_beef);
        chk("oor_rd_err", 32'(er[0]), 32'd1);
        step(0, 1, 1, 4'hf, 32'h4000, 32'hffff_ffff);
        chk("oor_wr_data", rd0, 32'hdead_beef);
        chk("oor_wr_err", 32'(er[0]), 32'd1);
        step(0, 1, 0, 4'h0, 32'h0, 32'h0);
        chk("oor_no_alias", rd0, 32'h0bad_f00d);
        step(0, 1, 0, 4'h0, 32'h3ffc, 32'h0);
        chk("last_word_err", 32'(er[0]), 32'd0);
        chk("last_word_data", rd0, 32'h7777_8888);
        step(0, 1, 1, 4'h0, 32'h3ffc, 32'h0);
        chk("be0000_resp", 32'(rv[0]), 32'd1);
        step(0, 1, 0, 4'h0, 32'h3ffc, 32'h0);
        chk("be0000_noop", rd0, 32'h7777_8888);

        for (int i = 0; i < 6; i++) idle();

        // stalled access: busy for 3 cycles, second request dropped
        step(0, 1, 1, 4'hf, 32'h40, 32'hcafe_f00d);
        chk("w3_busy1", 32'(rdy[1]), 32'd0);
        step(0, 1, 0, 4'h0, 32'h44, 32'h0);
        chk("w3_busy2", 32'(rdy[1]), 32'd0);
        chk("w3_no_early", 32'(rv[1]), 32'd0);
        idle();
        chk("w3_busy3", 32'(rdy[1]), 32'd0);
        idle();
        chk("w3_pulse", 32'(rv[1]), 32'd1);
        chk("w3_ready_back", 32'(rdy[1]), 32'd1);
        idle();
        chk("w3_single", 32'(rv[1]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("w3_dropped_req", 32'(rv[1]), 32'd0);
        end

        // reset two edges into a stalled write drops it
        step(0, 1, 1, 4'hf, 32'h40, 32'h0bad_c0de);
        idle();
        step(1, 0, 0, 4'h0, 32'h0, 32'h0);
        chk("rst_wait_ready", 32'(rdy[1]), 32'd1);
        chk("rst_wait_rv", 32'(rv[1]), 32'd0);
        idle();
        chk("rst_wait_rv2", 32'(rv[1]), 32'd0);
        step(0, 1, 0, 4'h0, 32'h40, 32'h0);
        idle(); idle(); idle();
        chk("rst_wait_rv3", 32'(rv[1]), 32'd1);
        chk("rst_wait_old", rd1, 32'hcafe_f00d);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                 $urandom_range(0, 1), 4'($urandom), rand_addr(), $urandom);
        end
        for (int i = 0; i < 6; i++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
